// File: rtl/reg_wr_arb_rr.sv
// reg_wr_arb_rr
// Round-robin write arbiter that shares one enabled data register among
// REQ_NUM requesters. One requester is granted at a time. The grant stays
// locked for a whole burst, and a burst ends on a beat flagged with last.
// Accepted beats reach the register through registered enable/data outputs,
// one cycle after the handshake.
//
// Optional feature (compile-time macro REG_WR_ARB_RR_TIMEOUT_EN):
//   When defined, a stalled owner (granted valid low) loses the grant after
//   TIMEOUT_CYCLES consecutive stall cycles. No write is issued on timeout.
//   When undefined, a stalled owner keeps the grant indefinitely.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester beat valid
//   i_req_last   per-requester last-beat flag (meaningful with valid)
//   i_req_data   requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready  one-hot ready for the granted requester while busy, else 0
//   o_reg_en     registered write enable to the shared register
//   o_reg_data   registered write data (holds when o_reg_en is low)
//   o_grant_id   index of the current or most recent grant
//   o_busy       high while a grant is held
module reg_wr_arb_rr #(
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_NUM        = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDW           = $clog2(REQ_NUM)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [REQ_NUM-1:0]            i_req_valid,
  input  logic [REQ_NUM-1:0]            i_req_last,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_data,
  output logic [REQ_NUM-1:0]            o_req_ready,
  output logic                          o_reg_en,
  output logic [DATA_WIDTH-1:0]         o_reg_data,
  output logic [IDW-1:0]                o_grant_id,
  output logic                          o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [REQ_NUM-1:0]      ready_q, ready_d;
  logic                    reg_en_q, reg_en_d;
  logic [DATA_WIDTH-1:0]   reg_data_q, reg_data_d;

  logic                    pick_found_s;
  logic [IDW-1:0]          pick_id_s;
  logic [IDW-1:0]          cand_s;
  logic                    xfer_s;

  // Index increment with wrap from REQ_NUM-1 back to 0; works for any REQ_NUM.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    if (idx == IDW'(REQ_NUM - 1)) begin
      return '0;
    end else begin
      return idx + IDW'(1);
    end
  endfunction

`ifdef REG_WR_ARB_RR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  // Round-robin pick: first valid requester at or above ptr, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    cand_s       = ptr_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!pick_found_s && i_req_valid[cand_s]) begin
        pick_found_s = 1'b1;
        pick_id_s    = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
      cand_s = wrap_inc(cand_s);
    end
  end

  // Next-state, grant bookkeeping and write-port decode.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    reg_en_d   = 1'b0;
    reg_data_d = reg_data_q;
`ifdef REG_WR_ARB_RR_TIMEOUT_EN
    cnt_d      = '0;
`endif
    // ready_q mirrors BUSY + grant, so this equals valid & ready for the owner.
    xfer_s     = (state_q == ST_BUSY) && i_req_valid[grant_q];

    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_BUSY;
          grant_d = pick_id_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (xfer_s) begin
          reg_en_d   = 1'b1;
          reg_data_d = i_req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
          if (i_req_last[grant_q]) begin
            state_d = ST_IDLE;
            ptr_d   = wrap_inc(grant_q);
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
`ifdef REG_WR_ARB_RR_TIMEOUT_EN
          // Counter holds the number of stall cycles already seen; this one
          // is the TIMEOUT_CYCLES-th when it equals TIMEOUT_CYCLES-1.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_IDLE;
            ptr_d   = wrap_inc(grant_q);
            cnt_d   = '0;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = cnt_q + CNT_W'(1);
          end
`else
          state_d = ST_BUSY;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_BUSY) begin
      ready_d = {{(REQ_NUM-1){1'b0}}, 1'b1} << grant_d;
    end else begin
      ready_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      ready_q    <= '0;
      reg_en_q   <= 1'b0;
      reg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      ready_q    <= ready_d;
      reg_en_q   <= reg_en_d;
      reg_data_q <= reg_data_d;
    end
  end

`ifdef REG_WR_ARB_RR_TIMEOUT_EN
  // Stall counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign o_req_ready = ready_q;
  assign o_reg_en    = reg_en_q;
  assign o_reg_data  = reg_data_q;
  assign o_grant_id  = grant_q;
  assign o_busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_reg_wr_arb_rr.sv
// Self-checking bench for reg_wr_arb_rr (DATA_WIDTH=32, REQ_NUM=4):
// directed vector table, hand-written reset/stall sequences, then random
// traffic compared against a behavioural arbiter model.
module tb_reg_wr_arb_rr;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   vld = '0;
  logic [N-1:0]   lst = '0;
  logic [N*DW-1:0] dat = '0;
  logic [N-1:0]   rdy;
  logic           en;
  logic [DW-1:0]  rdat;
  logic [1:0]     gid;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_wr_arb_rr #(.DATA_WIDTH(DW), .REQ_NUM(N), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vld), .i_req_last(lst),
    .i_req_data(dat), .o_req_ready(rdy), .o_reg_en(en), .o_reg_data(rdat),
    .o_grant_id(gid), .o_busy(busy)
  );

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   last;
    logic [127:0] data;
    logic [3:0]   rdy;
    logic         en;
    logic [31:0]  rdata;
    logic [1:0]   gid;
    logic         busy;
  } vec_t;

  vec_t tbl [0:18];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_rdy, input logic e_en,
                         input logic [31:0] e_data, input logic [1:0] e_gid, input logic e_busy);
    chk({tag, ".ready"}, 128'(rdy), 128'(e_rdy));
    chk({tag, ".reg_en"}, 128'(en), 128'(e_en));
    chk({tag, ".reg_data"}, 128'(rdat), 128'(e_data));
    chk({tag, ".grant_id"}, 128'(gid), 128'(e_gid));
    chk({tag, ".busy"}, 128'(busy), 128'(e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  logic       m_busy;
  int         m_owner, m_ptr, m_stall;
  logic       m_en;
  logic [31:0] m_data;

  initial begin
    logic [127:0] da, de;
    da = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    de = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    //           valid    last     data                                       rdy      en    rdata          gid    busy
    tbl[0]  = '{4'b0100, 4'b0100, {32'h0, 32'hFFFF00FF, 32'h0, 32'h0},       4'b0100, 1'b0, 32'h0,        2'd2, 1'b1};
    tbl[1]  = '{4'b0100, 4'b0100, {32'h0, 32'hFFFF00FF, 32'h0, 32'h0},       4'b0000, 1'b1, 32'hFFFF00FF, 2'd2, 1'b0};
    tbl[2]  = '{4'b0000, 4'b0000, 128'h0,                                    4'b0000, 1'b0, 32'hFFFF00FF, 2'd2, 1'b0};
    tbl[3]  = '{4'b1111, 4'b1111, da,                                        4'b1000, 1'b0, 32'hFFFF00FF, 2'd3, 1'b1};
    tbl[4]  = '{4'b1111, 4'b1111, da,                                        4'b0000, 1'b1, 32'hA3,       2'd3, 1'b0};
    tbl[5]  = '{4'b1111, 4'b1111, da,                                        4'b0001, 1'b0, 32'hA3,       2'd0, 1'b1};
    tbl[6]  = '{4'b1111, 4'b1111, da,                                        4'b0000, 1'b1, 32'hA0,       2'd0, 1'b0};
    tbl[7]  = '{4'b1111, 4'b1111, da,                                        4'b0010, 1'b0, 32'hA0,       2'd1, 1'b1};
    tbl[8]  = '{4'b1111, 4'b1111, da,                                        4'b0000, 1'b1, 32'hA1,       2'd1, 1'b0};
    tbl[9]  = '{4'b1111, 4'b1111, da,                                        4'b0100, 1'b0, 32'hA1,       2'd2, 1'b1};
    tbl[10] = '{4'b1111, 4'b1111, da,                                        4'b0000, 1'b1, 32'hA2,       2'd2, 1'b0};
    tbl[11] = '{4'b0010, 4'b0000, {32'h0, 32'h0, 32'h1, 32'h0},              4'b0010, 1'b0, 32'hA2,       2'd1, 1'b1};
    tbl[12] = '{4'b0011, 4'b0000, {32'h0, 32'h0, 32'h1, 32'hB0},             4'b0010, 1'b1, 32'h1,        2'd1, 1'b1};
    tbl[13] = '{4'b0011, 4'b0000, {32'h0, 32'h0, 32'h2, 32'hB0},             4'b0010, 1'b1, 32'h2,        2'd1, 1'b1};
    tbl[14] = '{4'b0011, 4'b0010, {32'h0, 32'h0, 32'h3, 32'hB0},             4'b0000, 1'b1, 32'h3,        2'd1, 1'b0};
    tbl[15] = '{4'b0001, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hB0},             4'b0001, 1'b0, 32'h3,        2'd0, 1'b1};
    tbl[16] = '{4'b0001, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hB0},             4'b0000, 1'b1, 32'hB0,       2'd0, 1'b0};
    tbl[17] = '{4'b0100, 4'b0000, {32'h0, 32'hC0, 32'h0, 32'h0},             4'b0100, 1'b0, 32'hB0,       2'd2, 1'b1};
    tbl[18] = '{4'b0100, 4'b0000, {32'h0, 32'hC0, 32'h0, 32'h0},             4'b0100, 1'b1, 32'hC0,       2'd2, 1'b1};

    // Reset with every requester valid: all outputs low.
    vld = 4'b1111; lst = 4'b1111; dat = de;
    #1;
    chk_all("reset", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0);
    step(); step();
    rst_n = 1'b1;
    // Fairness from ptr 0: grants 0,1,2,3,0 with one bubble in between.
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all($sformatf("fair_grant%0d", k), 4'(1 << (k % 4)), 1'b0,
              (k == 0) ? 32'h0 : 32'hE0 + 32'((k + 3) % 4), 2'(k % 4), 1'b1);
      step();
      chk_all($sformatf("fair_write%0d", k), 4'b0000, 1'b1, 32'hE0 + 32'(k % 4), 2'(k % 4), 1'b0);
    end

    // Asynchronous reset mid-cycle, then directed vector table from ptr 0.
    #2 rst_n = 1'b0;
    #1 chk_all("reset2", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0);
    vld = '0; lst = '0; dat = '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i <= 18; i++) begin
      vld = tbl[i].valid; lst = tbl[i].last; dat = tbl[i].data;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].rdata, tbl[i].gid, tbl[i].busy);
    end

    // Owner 2 stalls mid-burst while requester 3 waits.
    vld = 4'b1000; lst = 4'b1000; dat = {32'hD3, 96'h0};
`ifdef REG_WR_ARB_RR_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      step();
      chk_all($sformatf("stall%0d", c), 4'b0100, 1'b0, 32'hC0, 2'd2, 1'b1);
    end
    step();
    chk_all("timeout", 4'b0000, 1'b0, 32'hC0, 2'd2, 1'b0);
    step();
    chk_all("after_timeout", 4'b1000, 1'b0, 32'hC0, 2'd3, 1'b1);
    step();
    chk_all("after_timeout_wr", 4'b0000, 1'b1, 32'hD3, 2'd3, 1'b0);
`else
    for (int c = 1; c <= 40; c++) begin
      step();
      chk_all($sformatf("stall%0d", c), 4'b0100, 1'b0, 32'hC0, 2'd2, 1'b1);
    end
    vld = 4'b1100; lst = 4'b1100; dat = {32'hD3, 32'hC1, 64'h0};
    step();
    chk_all("stall_resume", 4'b0000, 1'b1, 32'hC1, 2'd2, 1'b0);
    step();
    chk_all("waiter_granted", 4'b1000, 1'b0, 32'hC1, 2'd3, 1'b1);
`endif

    // Reset after beat 1 of a 3-beat burst from requester 1.
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vld = 4'b0010; lst = 4'b0000; dat = {64'h0, 32'h11, 32'h0};
    step();
    chk_all("mb_grant", 4'b0010, 1'b0, 32'h0, 2'd1, 1'b1);
    step();
    chk_all("mb_beat1", 4'b0010, 1'b1, 32'h11, 2'd1, 1'b1);
    vld = 4'b1111; dat = {64'h0, 32'h12, 32'h0};
    #2 rst_n = 1'b0;
    #1 chk_all("mb_reset", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_all("mb_restart", 4'b0001, 1'b0, 32'h0, 2'd0, 1'b1);

    // Random traffic against the behavioural model (fresh reset).
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_stall = 0; m_en = 1'b0; m_data = '0;
    for (int t = 0; t < 3000; t++) begin
      logic found;
      vld = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      lst = 4'($urandom_range(0, 15));
      dat = {$urandom, $urandom, $urandom, $urandom};
      m_en = 1'b0;
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && vld[(m_ptr + k) % N]) begin
            found   = 1'b1;
            m_busy  = 1'b1;
            m_owner = (m_ptr + k) % N;
            m_stall = 0;
          end
        end
      end else if (vld[m_owner]) begin
        m_en    = 1'b1;
        m_data  = dat[m_owner*DW +: DW];
        m_stall = 0;
        if (lst[m_owner]) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % N;
        end
      end else begin
        m_stall++;
`ifdef REG_WR_ARB_RR_TIMEOUT_EN
        if (m_stall == TO) begin
          m_busy  = 1'b0;
          m_ptr   = (m_owner + 1) % N;
          m_stall = 0;
        end
`endif
      end
      step();
      chk_all($sformatf("rnd%0d", t), m_busy ? 4'(1 << m_owner) : 4'b0000,
              m_en, m_data, 2'(m_owner), m_busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
